// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared types and constants for the divider arbiter
package div_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 127;
    localparam logic [63:0] ALL_ONES = '1;
endpackage

// File: rtl/div_arbiter_if.sv
// rtl/div_arbiter_if.sv - requester and divider signal bundle for div_arbiter
interface div_arbiter_if
    import div_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_dv;
    logic [NREQ*WIDTH-1:0] req_dr;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_quotient;
    logic                  resp_div0;
    logic                  resp_timeout;
    logic                  div_init;
    logic [WIDTH-1:0]      div_dv;
    logic [WIDTH-1:0]      div_dr;
    logic                  div_ready;
    logic [WIDTH-1:0]      div_result;

    modport slave (
        input  req_valid, req_dv, req_dr, div_ready, div_result,
        output req_ready, resp_valid, resp_quotient, resp_div0, resp_timeout,
               div_init, div_dv, div_dr
    );

    modport master (
        output req_valid, req_dv, req_dr, div_ready, div_result,
        input  req_ready, resp_valid, resp_quotient, resp_div0, resp_timeout,
               div_init, div_dv, div_dr
    );
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select, scanning from i_last+1
module rr_picker #(
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [GW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [GW-1:0]   o_idx,
    output logic            o_any
);
    always_comb begin
        int w_idx;
        w_idx   = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Last granted port is visited last, so it has lowest priority.
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = int'(i_last) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!o_any && i_valid[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = GW'(w_idx);
            end
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one divider among NREQ requesters
module div_arbiter
    import div_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    div_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

    state_t           r_state, w_state_n;
    logic [GW-1:0]    r_last, w_last_n, r_owner, w_owner_n;
    logic [WIDTH-1:0] r_dv, w_dv_n, r_dr, w_dr_n, r_quot, w_quot_n;
    logic [CW-1:0]    r_cnt, w_cnt_n;
    logic             r_div0, w_div0_n, r_tmo, w_tmo_n;
    logic [NREQ-1:0]  r_req_ready, w_req_ready_n, r_resp_valid, w_resp_valid_n;
    logic [WIDTH-1:0] r_resp_q, w_resp_q_n;
    logic             r_resp_div0, w_resp_div0_n, r_resp_tmo, w_resp_tmo_n;
    logic             r_div_init, w_div_init_n;
    logic [NREQ-1:0]  w_grant;
    logic [GW-1:0]    w_gidx;
    logic             w_any;
    logic [WIDTH-1:0] w_sel_dv, w_sel_dr;

    rr_picker #(.NREQ(NREQ), .GW(GW)) u_pick (
        .i_valid (bus.req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    assign w_sel_dv = bus.req_dv[w_gidx*WIDTH +: WIDTH];
    assign w_sel_dr = bus.req_dr[w_gidx*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last       <= GW'(NREQ - 1);
            r_owner      <= '0;
            r_dv         <= '0;
            r_dr         <= '0;
            r_quot       <= '0;
            r_cnt        <= '0;
            r_div0       <= 1'b0;
            r_tmo        <= 1'b0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_q     <= '0;
            r_resp_div0  <= 1'b0;
            r_resp_tmo   <= 1'b0;
            r_div_init   <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_last       <= w_last_n;
            r_owner      <= w_owner_n;
            r_dv         <= w_dv_n;
            r_dr         <= w_dr_n;
            r_quot       <= w_quot_n;
            r_cnt        <= w_cnt_n;
            r_div0       <= w_div0_n;
            r_tmo        <= w_tmo_n;
            r_req_ready  <= w_req_ready_n;
            r_resp_valid <= w_resp_valid_n;
            r_resp_q     <= w_resp_q_n;
            r_resp_div0  <= w_resp_div0_n;
            r_resp_tmo   <= w_resp_tmo_n;
            r_div_init   <= w_div_init_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_last_n       = r_last;
        w_owner_n      = r_owner;
        w_dv_n         = r_dv;
        w_dr_n         = r_dr;
        w_quot_n       = r_quot;
        w_cnt_n        = r_cnt;
        w_div0_n       = r_div0;
        w_tmo_n        = r_tmo;
        w_req_ready_n  = '0;
        w_resp_valid_n = '0;
        w_resp_q_n     = '0;
        w_resp_div0_n  = 1'b0;
        w_resp_tmo_n   = 1'b0;
        w_div_init_n   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_req_ready_n = w_grant;
                    w_owner_n     = w_gidx;
                    w_last_n      = w_gidx;
                    w_dv_n        = w_sel_dv;
                    w_dr_n        = w_sel_dr;
                    w_tmo_n       = 1'b0;
                    if (w_sel_dr == '0) begin
                        w_state_n = ST_RESP;
                        w_quot_n  = ALL_ONES[WIDTH-1:0];
                        w_div0_n  = 1'b1;
                    end else begin
                        w_state_n    = ST_ISSUE;
                        w_div_init_n = 1'b1;
                        w_quot_n     = '0;
                        w_div0_n     = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_n = ST_WAIT;
                w_cnt_n   = '0;
            end
            ST_WAIT: begin
                // div_ready may still be high from the previous result on the first cycle.
                if (r_cnt != '0 && bus.div_ready) begin
                    w_quot_n  = bus.div_result;
                    w_state_n = ST_RESP;
                end else if (r_cnt == T_LAST) begin
                    w_quot_n  = '0;
                    w_tmo_n   = 1'b1;
                    w_state_n = ST_RESP;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                w_state_n      = ST_IDLE;
                w_resp_valid_n = NREQ'(1) << r_owner;
                w_resp_q_n     = r_quot;
                w_resp_div0_n  = r_div0;
                w_resp_tmo_n   = r_tmo;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_quotient = r_resp_q;
    assign bus.resp_div0     = r_resp_div0;
    assign bus.resp_timeout  = r_resp_tmo;
    assign bus.div_init      = r_div_init;
    assign bus.div_dv        = r_dv;
    assign bus.div_dr        = r_dr;
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter
module tb_div_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_arbiter_if #(.NREQ(NREQ), .WIDTH(W)) bus();

    div_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(127)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Divider stand-in: result two cycles after init unless stub_dead.
    bit stub_dead = 1'b0;
    int dlat = 0;
    initial begin
        bus.div_ready  = 1'b0;
        bus.div_result = '0;
    end
    always @(negedge clk) begin
        if (bus.div_init) begin
            bus.div_ready = 1'b0;
            dlat = stub_dead ? 0 : 2;
        end else if (dlat > 0) begin
            dlat = dlat - 1;
            if (dlat == 0) begin
                bus.div_ready  = 1'b1;
                bus.div_result = bus.div_dv / bus.div_dr;
            end
        end
    end

    int n_init = 0;
    int n_acc[NREQ] = '{default: 0};
    int acc_log[$];
    bit outst = 1'b0;
    bit overlap = 1'b0;
    always @(negedge clk) begin
        if (bus.resp_valid != '0) outst = 1'b0;
        if (bus.req_ready != '0) begin
            if (outst) overlap = 1'b1;
            outst = 1'b1;
            for (int p = 0; p < NREQ; p++)
                if (bus.req_ready[p]) begin
                    n_acc[p] = n_acc[p] + 1;
                    acc_log.push_back(p);
                end
        end
        if (bus.div_init) n_init = n_init + 1;
        if (!rst_n) outst = 1'b0;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [W-1:0] dv, input logic [W-1:0] dr);
        bus.req_dv[p*W +: W] = dv;
        bus.req_dr[p*W +: W] = dr;
    endtask

    task automatic wait_resp(input int max, output logic [NREQ-1:0] v, output logic [W-1:0] q,
                             output logic d0, output logic tm, output int cyc);
        v = '0; q = '0; d0 = 1'b0; tm = 1'b0; cyc = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (bus.resp_valid != '0) begin
                v = bus.resp_valid; q = bus.resp_quotient;
                d0 = bus.resp_div0; tm = bus.resp_timeout; cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_vec++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        n_vec++; if (bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 0000", bus.resp_valid); end
        n_vec++; if (bus.div_init !== 1'b0) begin n_err++; $display("FAIL reset_div_init: got %b expected 0", bus.div_init); end
        n_vec++; if ({bus.resp_quotient, bus.resp_div0, bus.resp_timeout} !== 34'h0) begin n_err++; $display("FAIL reset_resp_bus: got %h expected 0", {bus.resp_quotient, bus.resp_div0, bus.resp_timeout}); end
        n_vec++; if ({bus.div_dv, bus.div_dr} !== 64'h0) begin n_err++; $display("FAIL reset_div_ops: got %h expected 0", {bus.div_dv, bus.div_dr}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rr_all();
        int got_p[$];
        logic [W-1:0] got_q[$];
        logic [W-1:0] exp_q[4] = '{32'd14, 32'd100, 32'd9, 32'h7FFF_FFFF};
        set_port(0, 32'd100, 32'd7);
        set_port(1, 32'd1000, 32'd10);
        set_port(2, 32'd81, 32'd9);
        set_port(3, 32'hFFFF_FFFF, 32'd2);
        acc_log.delete();
        overlap = 1'b0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 300 && got_p.size() < 4; i++) begin
            tick();
            for (int p = 0; p < NREQ; p++) begin
                if (bus.req_ready[p]) bus.req_valid[p] = 1'b0;
                if (bus.resp_valid[p]) begin got_p.push_back(p); got_q.push_back(bus.resp_quotient); end
            end
        end
        bus.req_valid = '0;
        n_vec++; if (got_p.size() != 4 || acc_log.size() != 4) begin n_err++; $display("FAIL rr_all_count: got %0d resp %0d acc expected 4 4", got_p.size(), acc_log.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++; if (acc_log[k] != k) begin n_err++; $display("FAIL rr_all_order[%0d]: got port %0d expected %0d", k, acc_log[k], k); end
                n_vec++; if (got_p[k] != k || got_q[k] !== exp_q[k]) begin n_err++; $display("FAIL rr_all_resp[%0d]: got port %0d q %h expected port %0d q %h", k, got_p[k], got_q[k], k, exp_q[k]); end
            end
        end
        n_vec++; if (overlap !== 1'b0) begin n_err++; $display("FAIL rr_all_outstanding: got overlap %b expected 0", overlap); end
    endtask

    task automatic test_rr_rotate();
        logic [NREQ-1:0] v; logic [W-1:0] q; logic d0, tm; int cyc;
        set_port(0, 32'd12, 32'd4);
        set_port(2, 32'd40, 32'd8);
        bus.req_valid = 4'b0101;
        tick();
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rotate_first: got %b expected 0001", bus.req_ready); end
        bus.req_valid[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.req_ready != '0) break;
        end
        n_vec++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL rotate_second: got %b expected 0100", bus.req_ready); end
        bus.req_valid = '0;
        wait_resp(50, v, q, d0, tm, cyc);
        n_vec++; if (v !== 4'b0100 || q !== 32'd5) begin n_err++; $display("FAIL rotate_resp: got %b q %h expected 0100 q 5", v, q); end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] v; logic [W-1:0] q; logic d0, tm; int cyc;
        int i0, a0;
        i0 = n_init; a0 = n_acc[0];
        set_port(0, 32'd100, 32'd7);
        bus.req_valid = 4'b0001;
        tick();
        n_vec++; if (bus.req_ready !== 4'b0001 || bus.div_init !== 1'b1) begin n_err++; $display("FAIL single_accept: got ready %b init %b expected 0001 1", bus.req_ready, bus.div_init); end
        n_vec++; if (bus.div_dv !== 32'd100 || bus.div_dr !== 32'd7) begin n_err++; $display("FAIL single_ops: got %0d/%0d expected 100/7", bus.div_dv, bus.div_dr); end
        bus.req_valid = '0;
        wait_resp(50, v, q, d0, tm, cyc);
        n_vec++; if (v !== 4'b0001 || q !== 32'd14 || d0 !== 1'b0 || tm !== 1'b0) begin n_err++; $display("FAIL single_resp: got %b q %0d d0 %b to %b expected 0001 14 0 0", v, q, d0, tm); end
        tick();
        n_vec++; if (bus.resp_valid !== 4'b0 || bus.resp_quotient !== 32'h0) begin n_err++; $display("FAIL single_idle_bus: got %b q %h expected 0000 0", bus.resp_valid, bus.resp_quotient); end
        n_vec++; if (n_init - i0 != 1 || n_acc[0] - a0 != 1) begin n_err++; $display("FAIL single_pulses: got init %0d ready %0d expected 1 1", n_init - i0, n_acc[0] - a0); end
    endtask

    task automatic test_div0();
        int i0;
        i0 = n_init;
        set_port(1, 32'd5, 32'd0);
        bus.req_valid = 4'b0010;
        tick();
        n_vec++; if (bus.req_ready !== 4'b0010 || bus.div_init !== 1'b0) begin n_err++; $display("FAIL div0_accept: got ready %b init %b expected 0010 0", bus.req_ready, bus.div_init); end
        bus.req_valid = '0;
        tick();
        n_vec++; if (bus.resp_valid !== 4'b0010) begin n_err++; $display("FAIL div0_latency: got %b expected 0010", bus.resp_valid); end
        n_vec++; if (bus.resp_quotient !== 32'hFFFF_FFFF || bus.resp_div0 !== 1'b1 || bus.resp_timeout !== 1'b0) begin n_err++; $display("FAIL div0_resp: got q %h d0 %b to %b expected ffffffff 1 0", bus.resp_quotient, bus.resp_div0, bus.resp_timeout); end
        n_vec++; if (n_init != i0) begin n_err++; $display("FAIL div0_no_init: got %0d inits expected 0", n_init - i0); end
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] v; logic [W-1:0] q; logic d0, tm; int cyc;
        int a2;
        a2 = n_acc[2];
        stub_dead = 1'b1;
        set_port(3, 32'd50, 32'd5);
        set_port(2, 32'd8, 32'd2);
        bus.req_valid = 4'b1000;
        tick();
        n_vec++; if (bus.req_ready !== 4'b1000 || bus.div_init !== 1'b1) begin n_err++; $display("FAIL tmo_accept: got ready %b init %b expected 1000 1", bus.req_ready, bus.div_init); end
        bus.req_valid = '0;
        v = '0; q = 'x; d0 = 1'bx; tm = 1'bx; cyc = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (i == 10) bus.req_valid[2] = 1'b1;
            if (i == 20) bus.req_valid[2] = 1'b0;
            if (bus.resp_valid != '0) begin
                v = bus.resp_valid; q = bus.resp_quotient; d0 = bus.resp_div0; tm = bus.resp_timeout; cyc = i;
                break;
            end
        end
        n_vec++; if (cyc != 129) begin n_err++; $display("FAIL tmo_latency: got %0d cycles after init expected 129", cyc); end
        n_vec++; if (v !== 4'b1000 || q !== 32'h0 || tm !== 1'b1 || d0 !== 1'b0) begin n_err++; $display("FAIL tmo_resp: got %b q %h to %b d0 %b expected 1000 0 1 0", v, q, tm, d0); end
        n_vec++; if (n_acc[2] != a2) begin n_err++; $display("FAIL dropped_valid: got %0d accepts on port 2 expected 0", n_acc[2] - a2); end
        stub_dead = 1'b0;
        set_port(0, 32'd9, 32'd3);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        wait_resp(50, v, q, d0, tm, cyc);
        n_vec++; if (v !== 4'b0001 || q !== 32'd3 || tm !== 1'b0) begin n_err++; $display("FAIL tmo_recover: got %b q %0d to %b expected 0001 3 0", v, q, tm); end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] v; logic [W-1:0] q; logic d0, tm; int cyc;
        int stale;
        stub_dead = 1'b1;
        set_port(1, 32'd20, 32'd4);
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({bus.div_dv, bus.div_dr} !== 64'h0) begin n_err++; $display("FAIL async_reset_ops: got %h expected 0", {bus.div_dv, bus.div_dr}); end
        n_vec++; if (bus.req_ready !== 4'b0 || bus.resp_valid !== 4'b0 || bus.div_init !== 1'b0) begin n_err++; $display("FAIL async_reset_ctl: got %b %b %b expected 0", bus.req_ready, bus.resp_valid, bus.div_init); end
        tick(); tick();
        rst_n = 1'b1;
        stub_dead = 1'b0;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.resp_valid != '0) stale++;
        end
        n_vec++; if (stale != 0) begin n_err++; $display("FAIL stale_resp: got %0d responses expected 0", stale); end
        set_port(2, 32'hFFFF_FFFF, 32'h10);
        bus.req_valid = 4'b0100;
        tick();
        n_vec++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL post_reset_accept: got %b expected 0100", bus.req_ready); end
        bus.req_valid = '0;
        wait_resp(50, v, q, d0, tm, cyc);
        n_vec++; if (v !== 4'b0100 || q !== 32'h0FFF_FFFF) begin n_err++; $display("FAIL post_reset_resp: got %b q %h expected 0100 0fffffff", v, q); end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_dv    = '0;
        bus.req_dr    = '0;
        test_reset();
        test_rr_all();
        test_rr_rotate();
        test_single();
        test_div0();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
        $fatal(1);
    end
endmodule
